// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and IF/ID register and drives a variable-latency req/ack imem port.
// Optional performance counters (fetch_cnt_o, stall_cnt_o) are built only when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef IF_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              imem_req_o,
    output logic [31:0]       imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       PC,
    output logic [31:0]       if_id_instr_o,
    output logic [31:0]       if_id_pc4_o,
    output logic              if_id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  fetch_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic        req_q;
    logic [31:0] buf_q;
    logic        pend_q;
    logic [31:0] pend_pc_q;

    logic [31:0] pc_plus4_c;
    logic [31:0] target_c;
    logic        deliver_c;

    // Next-PC arithmetic and "IF/ID receives a real instruction this edge" decode
    always_comb begin
        pc_plus4_c = pc_q + 32'd4;
        target_c   = redirect_pc_i & 32'hFFFF_FFFC;
        deliver_c  = 1'b0;
        if (!redirect_i && !flush_i && !stall_i) begin
            if (state == HOLD)
                deliver_c = 1'b1;
            else if (state == FETCH && imem_ack_i && !pend_q)
                deliver_c = 1'b1;
        end
    end

    // Fetch FSM; imem_req_o is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc4_q     <= 32'h0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            buf_q     <= 32'h0;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (redirect_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        if (imem_ack_i) begin
                            pc_q   <= target_c;
                            pend_q <= 1'b0;
                        end else begin
                            pend_q    <= 1'b1;
                            pend_pc_q <= target_c;
                        end
                    end else if (flush_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        // an older pending redirect still wins once its request completes
                        if (imem_ack_i && pend_q) begin
                            pc_q   <= pend_pc_q;
                            pend_q <= 1'b0;
                        end
                    end else if (imem_ack_i && pend_q) begin
                        pc_q   <= pend_pc_q;
                        pend_q <= 1'b0;
                        if (!stall_i) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end else if (imem_ack_i && stall_i) begin
                        buf_q <= imem_rdata_i;
                        state <= HOLD;
                        req_q <= 1'b0;
                    end else if (imem_ack_i) begin
                        instr_q <= imem_rdata_i;
                        pc4_q   <= pc_plus4_c;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4_c;
                    end else if (!stall_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        pc_q    <= target_c;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                    end else if (flush_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                    end else if (!stall_i) begin
                        instr_q <= buf_q;
                        pc4_q   <= pc_plus4_c;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4_c;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating counters: delivered instructions vs. non-delivering cycles after boot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (state != BOOT) begin
            if (deliver_c) begin
                if (fetch_cnt_q != {CNT_W{1'b1}})
                    fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end else begin
                if (stall_cnt_q != {CNT_W{1'b1}})
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver_c;
`endif

    assign PC            = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = req_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle expected IF/ID contents queued with the stimulus and checked after the edge.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, redirect_i, imem_ack_i;
    logic [31:0] redirect_pc_i, imem_rdata_i;
    logic        imem_req_o, if_id_valid_o;
    logic [31:0] imem_addr_o, PC, if_id_instr_o, if_id_pc4_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .PC            (PC),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check pre-edge fetch port, queue expected IF/ID, compare after the edge
    task automatic step(input logic ack, input logic stl, input logic fl, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] exp_addr, input logic exp_req,
                        input logic [31:0] exp_instr, input logic [31:0] exp_pc4, input logic exp_valid);
        exp_t e;
        imem_ack_i    = ack;
        imem_rdata_i  = exp_addr | 32'hA000_0000;
        stall_i       = stl;
        flush_i       = fl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        chk("imem_addr", imem_addr_o, exp_addr);
        chk("pc_port", PC, exp_addr);
        chk("imem_req", {31'h0, imem_req_o}, {31'h0, exp_req});
        e.instr = exp_instr;
        e.pc4   = exp_pc4;
        e.valid = exp_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("if_id_valid", {31'h0, if_id_valid_o}, {31'h0, e.valid});
        chk("if_id_instr", if_id_instr_o, e.instr);
        if (e.valid)
            chk("if_id_pc4", if_id_pc4_o, e.pc4);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_req"}, {31'h0, imem_req_o}, 32'h0);
        chk({tag, "_instr"}, if_id_instr_o, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4_o, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_id_valid_o}, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fcnt"}, fetch_cnt_o, 32'h0);
        chk({tag, "_scnt"}, stall_cnt_o, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b0; stall_i = 0; flush_i = 0; redirect_i = 0; imem_ack_i = 0;
        redirect_pc_i = 32'h0; imem_rdata_i = 32'h0;
        #2;
        chk_reset_outputs("reset");
        #10;                          // release between edges; next edge ends BOOT
        rst = 1'b1;
        #1;
        chk("boot_req", {31'h0, imem_req_o}, 32'h0);
        @(posedge clk); #1;

        // streaming fetch, ack every cycle
        step(1,0,0,0,0, 32'h0,   1, 32'hA000_0000, 32'h4,  1);
        step(1,0,0,0,0, 32'h4,   1, 32'hA000_0004, 32'h8,  1);
        step(1,0,0,0,0, 32'h8,   1, 32'hA000_0008, 32'hC,  1);
        // ack delayed three cycles: sticky request, bubbles
        step(0,0,0,0,0, 32'hC,   1, 32'h0,         32'h0,  0);
        step(0,0,0,0,0, 32'hC,   1, 32'h0,         32'h0,  0);
        step(0,0,0,0,0, 32'hC,   1, 32'h0,         32'h0,  0);
        step(1,0,0,0,0, 32'hC,   1, 32'hA000_000C, 32'h10, 1);
        // redirect to 0x103 while 0x10 is outstanding
        step(0,0,0,1,32'h103, 32'h10, 1, 32'h0, 32'h0, 0);
        step(0,0,0,0,0, 32'h10,  1, 32'h0,         32'h0,  0);
        step(1,0,0,0,0, 32'h10,  1, 32'h0,         32'h0,  0);
        step(1,0,0,0,0, 32'h100, 1, 32'hA000_0100, 32'h104, 1);
        // stall coincident with ack: HOLD for two cycles
        step(1,1,0,0,0, 32'h104, 1, 32'hA000_0100, 32'h104, 1);
        step(0,1,0,0,0, 32'h104, 0, 32'hA000_0100, 32'h104, 1);
        step(0,0,0,0,0, 32'h104, 0, 32'hA000_0104, 32'h108, 1);
        // flush with ack: same PC refetched
        step(1,0,1,0,0, 32'h108, 1, 32'h0,         32'h0,   0);
        step(1,0,0,0,0, 32'h108, 1, 32'hA000_0108, 32'h10C, 1);
        // flush while in HOLD
        step(1,1,0,0,0, 32'h10C, 1, 32'hA000_0108, 32'h10C, 1);
        step(0,1,1,0,0, 32'h10C, 0, 32'h0,         32'h0,   0);
        step(1,0,0,0,0, 32'h10C, 1, 32'hA000_010C, 32'h110, 1);
        // redirect out of HOLD to the top of memory, then PC+4 wraps
        step(1,1,0,0,0, 32'h110, 1, 32'hA000_010C, 32'h110, 1);
        step(0,1,0,1,32'hFFFF_FFFE, 32'h110, 0, 32'h0, 32'h0, 0);
        step(1,0,0,0,0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 1);
        step(1,0,0,0,0, 32'h0,   1, 32'hA000_0000, 32'h4,   1);
        // newer redirect overwrites the latched target
        step(0,0,0,1,32'h200, 32'h4, 1, 32'h0, 32'h0, 0);
        step(0,0,0,1,32'h300, 32'h4, 1, 32'h0, 32'h0, 0);
        step(1,0,0,0,0, 32'h4,   1, 32'h0,         32'h0,   0);
        step(1,0,0,0,0, 32'h300, 1, 32'hA000_0300, 32'h304, 1);
        // redirect with ack outranks stall
        step(1,1,0,1,32'h40, 32'h304, 1, 32'h0, 32'h0, 0);
        step(1,0,0,0,0, 32'h40,  1, 32'hA000_0040, 32'h44,  1);
        // no ack under stall holds IF/ID
        step(0,1,0,0,0, 32'h44,  1, 32'hA000_0040, 32'h44,  1);
        // enter HOLD, then asynchronous reset between edges
        step(1,1,0,0,0, 32'h44,  1, 32'hA000_0040, 32'h44,  1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("reboot_req", {31'h0, imem_req_o}, 32'h0);
        @(posedge clk); #1;
        step(1,0,0,0,0, 32'h0,   1, 32'hA000_0000, 32'h4,   1);
        step(1,0,0,0,0, 32'h4,   1, 32'hA000_0004, 32'h8,   1);

        imem_ack_i = 0; stall_i = 0; flush_i = 0; redirect_i = 0;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
